// File: rtl/key_press_encoder.sv
// key_press_encoder: conditions the active-low game buttons into debounced
// key levels and turns each accepted press into a single one-hot note held
// under a valid/ack handshake. A key must be released before it can
// produce another note; simultaneous presses are flagged as an error.
module key_press_encoder #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic                enable,
    input  logic                press_ack,
    output logic                press_valid,
    output logic [NUM_KEYS-1:0] press_note,
    output logic [NUM_KEYS-1:0] keys_held,
    output logic                multi_press_error
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,   // waiting for every key to be released
        ST_ARMED = 2'b01,   // ready to accept a single press
        ST_VALID = 2'b10    // note pending until acknowledged
    } state_t;

    // Number of set bits, saturating at 2: 0 = none, 1 = exactly one, 2 = several.
    function automatic logic [1:0] count_sat2(input logic [NUM_KEYS-1:0] v);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i] && (n != 2'd2)) begin
                n = n + 2'd1;
            end
        end
        return n;
    endfunction

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] stable_r;
    logic [CNT_W-1:0]    cnt_r [NUM_KEYS];

    state_t              state_r;
    state_t              state_s;
    logic                valid_r;
    logic                valid_s;
    logic [NUM_KEYS-1:0] note_r;
    logic [NUM_KEYS-1:0] note_s;
    logic                err_r;
    logic                err_s;
    logic [1:0]          held_cnt_s;

    // Two-flop synchroniser per key, inverted so a pressed button reads as 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= ~keys_n;
            sync2_r <= sync1_r;
        end
    end

    // Per-key debounce: a level change is accepted only after the sample has
    // disagreed with the stable level long enough for the counter to reach
    // its limit; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_r <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (cnt_r[k] == CNT_MAX) begin
                    stable_r[k] <= ~stable_r[k];
                    cnt_r[k]    <= '0;
                end else if (sync2_r[k] != stable_r[k]) begin
                    cnt_r[k]    <= cnt_r[k] + CNT_ONE;
                end else begin
                    cnt_r[k]    <= '0;
                end
            end
        end
    end

    // Press FSM state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            note_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            note_r  <= note_s;
            err_r   <= err_s;
        end
    end

    // Next-state and next-output decode for the press FSM.
    always_comb begin
        state_s    = state_r;
        valid_s    = valid_r;
        note_s     = note_r;
        err_s      = 1'b0;
        held_cnt_s = count_sat2(stable_r);
        case (state_r)
            ST_IDLE: begin
                if (held_cnt_s == 2'd0) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (enable) begin
                    if (held_cnt_s == 2'd1) begin
                        state_s = ST_VALID;
                        valid_s = 1'b1;
                        note_s  = stable_r;
                    end else if (held_cnt_s == 2'd2) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_ARMED;
                    end
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_VALID: begin
                if (press_ack) begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    note_s  = '0;
                end else begin
                    state_s = ST_VALID;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                note_s  = '0;
            end
        endcase
    end

    assign press_valid       = valid_r;
    assign press_note        = note_r;
    assign keys_held         = stable_r;
    assign multi_press_error = err_r;

endmodule

// File: tb/tb_key_press_encoder.sv
// Bench for key_press_encoder: directed scenarios followed by randomized key
// traffic, all compared against a behavioural model of the button rules.
module tb_key_press_encoder;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int LAT = DB + 4;   // steps from a key change to press_valid

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys_n;
    logic          enable;
    logic          press_ack;
    logic          press_valid;
    logic [NK-1:0] press_note;
    logic [NK-1:0] keys_held;
    logic          multi_press_error;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    key_press_encoder #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
        .clk               (clk),
        .reset             (reset),
        .keys_n            (keys_n),
        .enable            (enable),
        .press_ack         (press_ack),
        .press_valid       (press_valid),
        .press_note        (press_note),
        .keys_held         (keys_held),
        .multi_press_error (multi_press_error)
    );

    // Behavioural model: raw levels pass through a two-deep delay queue; a
    // key's held level flips once the last DB samples all disagreed with it
    // and at least DB+1 edges have passed since its previous flip.
    logic [NK-1:0] sync_q[$];
    logic [NK-1:0] samp_hist[$];
    int            since_flip[NK];
    logic [NK-1:0] m_held;
    logic [NK-1:0] m_note;
    logic          m_valid;
    logic          m_err;
    int            m_mode;     // 0 waiting for release, 1 armed, 2 note pending

    task automatic m_reset();
        sync_q    = {};
        samp_hist = {};
        sync_q.push_back('0);
        sync_q.push_back('0);
        for (int i = 0; i < DB; i++) samp_hist.push_back('0);
        for (int k = 0; k < NK; k++) since_flip[k] = DB;
        m_held  = '0;
        m_note  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_mode  = 0;
    endtask

    task automatic m_edge(input logic [NK-1:0] raw, input logic en, input logic ack);
        logic [NK-1:0] samp;
        logic [NK-1:0] held_prev;
        logic [NK-1:0] held_new;
        bit            all_diff;
        samp = sync_q[0];
        void'(sync_q.pop_front());
        sync_q.push_back(raw);
        held_prev = m_held;
        held_new  = m_held;
        for (int k = 0; k < NK; k++) begin
            all_diff = 1'b1;
            foreach (samp_hist[i]) if (samp_hist[i][k] == m_held[k]) all_diff = 1'b0;
            if (all_diff && since_flip[k] >= DB) begin
                held_new[k]   = ~m_held[k];
                since_flip[k] = 0;
            end else begin
                since_flip[k] = since_flip[k] + 1;
            end
        end
        samp_hist.push_back(samp);
        void'(samp_hist.pop_front());
        m_held = held_new;
        m_err  = 1'b0;
        case (m_mode)
            2: if (ack) begin m_valid = 1'b0; m_note = '0; m_mode = 0; end
            1: if (en) begin
                if ($countones(held_prev) == 1) begin
                    m_note = held_prev; m_valid = 1'b1; m_mode = 2;
                end else if (held_prev != '0) begin
                    m_err = 1'b1; m_mode = 0;
                end
            end
            default: if (held_prev == '0) m_mode = 1;
        endcase
    endtask

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge(~keys_n, enable, press_ack);
        #1;
        chk("held", keys_held, m_held);
        chk("valid", NK'(press_valid), NK'(m_valid));
        chk("note", press_note, m_note);
        chk("err", NK'(multi_press_error), NK'(m_err));
    endtask

    task automatic ack_and_release();
        press_ack = 1'b1;
        step();
        press_ack = 1'b0;
        keys_n = '1;
        repeat (12) step();
    endtask

    initial begin
        reset     = 1'b1;
        keys_n    = '1;
        enable    = 1'b0;
        press_ack = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", NK'(press_valid), 4'b0000);
        chk("rst_note", press_note, 4'b0000);
        chk("rst_held", keys_held, 4'b0000);
        chk("rst_err", NK'(multi_press_error), 4'b0000);
        reset = 1'b0;

        // Clean press of key 2 with acknowledge.
        enable = 1'b1;
        keys_n = 4'b1011;
        repeat (DB + 2) step();
        chk("s1_held_early", keys_held, 4'b0000);
        step();
        chk("s1_held", keys_held, 4'b0100);
        chk("s1_valid_early", NK'(press_valid), 4'b0000);
        step();
        chk("s1_valid", NK'(press_valid), 4'b0001);
        chk("s1_note", press_note, 4'b0100);
        repeat (8) step();
        chk("s1_hold", press_note, 4'b0100);
        press_ack = 1'b1;
        step();
        chk("s1_ack_valid", NK'(press_valid), 4'b0000);
        chk("s1_ack_note", press_note, 4'b0000);
        press_ack = 1'b0;
        keys_n = '1;
        repeat (DB + 2) step();
        chk("s1_rel_early", keys_held, 4'b0100);
        step();
        chk("s1_rel", keys_held, 4'b0000);
        repeat (4) step();

        // Bounce on key 0, then a stable press.
        for (int i = 0; i < 6; i++) begin
            keys_n = (i % 2 == 0) ? 4'b1110 : 4'b1111;
            step();
            step();
            chk("s2_bounce_held", keys_held, 4'b0000);
        end
        keys_n = 4'b1110;
        repeat (LAT - 1) step();
        chk("s2_valid_early", NK'(press_valid), 4'b0000);
        step();
        chk("s2_valid", NK'(press_valid), 4'b0001);
        chk("s2_note", press_note, 4'b0001);
        ack_and_release();

        // Held key gives one event only.
        keys_n = 4'b1101;
        repeat (LAT) step();
        chk("s3_note1", press_note, 4'b0010);
        press_ack = 1'b1;
        step();
        press_ack = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i % 10 == 9) chk("s3_no_repeat", NK'(press_valid), 4'b0000);
        end
        keys_n = '1;
        repeat (12) step();
        keys_n = 4'b1101;
        repeat (LAT) step();
        chk("s3_note2", press_note, 4'b0010);
        ack_and_release();

        // Simultaneous keys 1 and 3.
        keys_n = 4'b0101;
        repeat (LAT) step();
        chk("s4_err", NK'(multi_press_error), 4'b0001);
        chk("s4_no_valid", NK'(press_valid), 4'b0000);
        step();
        chk("s4_err_pulse", NK'(multi_press_error), 4'b0000);
        keys_n = '1;
        repeat (12) step();
        keys_n = 4'b1110;
        repeat (LAT) step();
        chk("s4_note", press_note, 4'b0001);
        ack_and_release();

        // Enable gating with key 2 held.
        enable = 1'b0;
        keys_n = 4'b1011;
        repeat (28) step();
        chk("s5_gated", NK'(press_valid), 4'b0000);
        enable = 1'b1;
        step();
        chk("s5_valid", NK'(press_valid), 4'b0001);
        chk("s5_note", press_note, 4'b0100);

        // Reset asserted mid-cycle while a note is pending.
        #3;
        reset = 1'b1;
        #1;
        chk("s6_valid", NK'(press_valid), 4'b0000);
        chk("s6_note", press_note, 4'b0000);
        chk("s6_held", keys_held, 4'b0000);
        keys_n = '1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            if (i % 5 == 4) chk("s6_no_event", NK'(press_valid), 4'b0000);
        end

        // Randomized key traffic against the model.
        for (int seg = 0; seg < 150; seg++) begin
            logic [NK-1:0] pk;
            int            r;
            int            len;
            r = $urandom_range(0, 9);
            if (r < 4)      pk = NK'(1) << $urandom_range(0, NK - 1);
            else if (r < 6) pk = '0;
            else            pk = NK'($urandom);
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 20);
            keys_n = ~pk;
            if ($urandom_range(0, 4) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                #1;
                chk("rnd_rst_valid", NK'(press_valid), 4'b0000);
                chk("rnd_rst_held", keys_held, 4'b0000);
                m_reset();
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            for (int c = 0; c < len; c++) begin
                press_ack = ($urandom_range(0, 3) == 0);
                step();
            end
        end
        press_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_press_encoder.md
# key_press_encoder

Input conditioning stage for the memory game, sitting between the board push-buttons and the response checker. It synchronises and debounces the active-low keys and enforces one-press-per-release. Each accepted press is delivered as a single one-hot note held under a valid/ack handshake. The debounced key levels are also exported so that LED mirroring and the response logic never touch the raw buttons.

## Interface

Parameters:
- NUM_KEYS, 4, number of note keys.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples required to accept a level change. Must be ≥ 1. Counter width is clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; returns all state to reset values immediately.
- keys_n  in  NUM_KEYS  raw push-buttons, active-low, asynchronous to clk.
- enable  in  1  press acceptance enable, driven high by the controller while it is waiting for a response.
- press_ack  in  1  consumer has taken the current note.
- press_valid  out  1  a note is pending; held until acknowledged.
- press_note  out  NUM_KEYS  one-hot note; stable while press_valid=1, zero otherwise.
- keys_held  out  NUM_KEYS  debounced active-high key levels.
- multi_press_error  out  1  one-cycle pulse when more than one key is detected pressed at acceptance.

## Operation

- **Synchroniser.** Per-key 2-flop synchroniser, inverted to active-high.
- **Debounce, per key.** The block keeps a stable level and a counter for each key.
  - When the synchronised sample differs from the stable level, the counter increments.
  - When the sample equals the stable level, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - keys_held is the vector of stable levels.
- **FSM states.** IDLE, ARMED, VALID.
  - IDLE: if keys_held==0, go to ARMED; otherwise stay. This is the release wait.
  - ARMED, enable=0: stay; keys are ignored.
  - ARMED, enable=1, keys_held has exactly one bit set: load press_note with keys_held and go to VALID.
  - ARMED, enable=1, keys_held has two or more bits set: pulse multi_press_error for one cycle and go to IDLE.
  - ARMED, enable=1, keys_held==0: stay.
  - VALID: press_valid=1. On press_ack=1, clear press_note to 0 and go to IDLE. enable is ignored in VALID.
- **One event per press.** A key held after acknowledgement produces no further event. It must be released (all keys_held=0) and pressed again.
- **Staggered keys.** If a second key becomes stable one or more cycles after the first was accepted, it is ignored. It still blocks re-arming until released.
- **Enable raised while held.** Raising enable while a single key is held in ARMED accepts that key on the next edge.
- **Key held through reset.** Reported once as a press after debounce, provided enable=1.
- **press_ack outside VALID.** Ignored.

## Timing

- **Reset values.**
  - press_valid=0, press_note=0, keys_held=0, multi_press_error=0.
  - FSM=IDLE.
  - Synchroniser flops 0 (released), debounce counters 0.
- **Press latency.** For a clean press (keys_n low from edge E onward, with no other key active and enable=1 in ARMED), keys_held rises at edge E+2+DEBOUNCE_CYCLES. press_valid and press_note update at edge E+3+DEBOUNCE_CYCLES.
- **Release latency.** Symmetric: keys_held falls 2+DEBOUNCE_CYCLES edges after a clean release.
- **Acknowledge.** press_ack sampled high in VALID deasserts press_valid and clears press_note on that same edge. Earliest next press_valid is one edge after keys_held returns to 0 and a new stable press is seen: IDLE→ARMED takes 1 cycle, ARMED→VALID takes 1 cycle.
- **multi_press_error.** High for exactly the one cycle following the ARMED edge that detected the multi-press.
- **Reset mid-operation.** Any state, including VALID, drops all outputs to reset values asynchronously. There is no pending note after reset is released.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

1. **Clean press with acknowledge.** Stimulus: reset, enable=1, keys_n=4'b1011 from edge 10 held. Required: keys_held=4'b0100 at edge 16; press_valid=1 with press_note=4'b0100 at edge 17, held until press_ack. Ack at edge 25 gives press_valid=0 and press_note=0 after edge 25.
2. **Bounce rejection.** Stimulus: keys_n[0] toggles every 2 cycles for 12 cycles, then stays low. Required: no keys_held change during the bounce; exactly one press_valid with press_note=4'b0001, 7 edges after the final falling transition.
3. **Held key, one event only.** Stimulus: hold key 1, ack the event, keep holding for 50 cycles, release, press again. Required: no second press_valid while held; a second event with press_note=4'b0010 after the re-press.
4. **Simultaneous keys.** Stimulus: keys 1 and 3 go low on the same edge. Required: a single-cycle multi_press_error pulse and no press_valid; after both are released, a lone press of key 0 gives a normal event with press_note=4'b0001.
5. **Enable gating.** Stimulus: press key 2 with enable=0 and wait 20 cycles; then raise enable while the key is still held. Required: press_valid stays 0 while enable=0; press_valid=1 with press_note=4'b0100 one edge after enable rises.
6. **Reset during VALID.** Stimulus: assert reset mid-cycle while press_valid=1. Required: press_valid, press_note and keys_held are 0 before the next clock edge; after reset is released with keys released, no event occurs.
